// File: rtl/uart_text_ctrl.sv
// UART-to-OLED text sequencer: buffers one received byte, tracks the cursor and issues cell writes.
// Optional byte echo on tx_* ports is enabled by defining UART_TEXT_ECHO_EN.
module uart_text_ctrl #(
    parameter int         COLS   = 16,
    parameter int         ROWS   = 4,
    parameter int         ADDR_W = 6,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_char,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy,
    output logic                      overrun
`ifdef UART_TEXT_ECHO_EN
    ,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
`endif
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WRITE  = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               hold_full_q, hold_full_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_char_q, wr_char_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               advance_q, advance_d;
    logic               overrun_q, overrun_d;
    logic               hold_free_s;
    logic               leave_ok_s;
    logic               xfer_s;
    logic [ROW_W-1:0]   row_inc_s;
    logic [COL_W-1:0]   bs_col_s;
    logic [ROW_W-1:0]   bs_row_s;
`ifdef UART_TEXT_ECHO_EN
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
`endif

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    // Next-state, cursor and hold-register logic.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_char_d   = wr_char_q;
        col_d       = col_q;
        row_d       = row_q;
        advance_d   = advance_q;
        overrun_d   = overrun_q;
        hold_free_s = 1'b0;
        xfer_s      = wr_valid_q && wr_ready;
        row_inc_s   = (row_q == ROW_MAX) ? {ROW_W{1'b0}} : row_q + ROW_ONE;
        bs_col_s    = (col_q == {COL_W{1'b0}}) ? COL_MAX : col_q - COL_ONE;
        bs_row_s    = (col_q == {COL_W{1'b0}}) ? row_q - ROW_ONE : row_q;
`ifdef UART_TEXT_ECHO_EN
        leave_ok_s  = !tx_valid_q || tx_ready;
        tx_valid_d  = tx_valid_q && !tx_ready;
        tx_data_d   = tx_data_q;
`else
        leave_ok_s  = 1'b1;
`endif

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (leave_ok_s) begin
                    hold_free_s = 1'b1;
`ifdef UART_TEXT_ECHO_EN
                    tx_valid_d  = 1'b1;
                    tx_data_d   = hold_data_q;
`endif
                    if (hold_data_q >= 8'h20 && hold_data_q <= 8'h7E) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = cell_addr(row_q, col_q);
                        wr_char_d  = hold_data_q;
                        advance_d  = 1'b1;
                        state_d    = S_WRITE;
                    end else if (hold_data_q == 8'h0A || hold_data_q == 8'h0D) begin
                        col_d   = {COL_W{1'b0}};
                        row_d   = row_inc_s;
                        state_d = S_IDLE;
                    end else if (hold_data_q == 8'h08) begin
                        if (col_q == {COL_W{1'b0}} && row_q == {ROW_W{1'b0}}) begin
                            state_d = S_IDLE;
                        end else begin
                            // Backspace moves the cursor now; WRITE must not advance it again.
                            col_d      = bs_col_s;
                            row_d      = bs_row_s;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cell_addr(bs_row_s, bs_col_s);
                            wr_char_d  = BLANK;
                            advance_d  = 1'b0;
                            state_d    = S_WRITE;
                        end
                    end else if (hold_data_q == 8'h0C) begin
                        col_d      = {COL_W{1'b0}};
                        row_d      = {ROW_W{1'b0}};
                        wr_valid_d = 1'b1;
                        wr_addr_d  = {ADDR_W{1'b0}};
                        wr_char_d  = BLANK;
                        state_d    = S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_WRITE: begin
                if (xfer_s) begin
                    wr_valid_d = 1'b0;
                    state_d    = S_IDLE;
                    if (advance_q) begin
                        if (col_q == COL_MAX) begin
                            col_d = {COL_W{1'b0}};
                            row_d = row_inc_s;
                        end else begin
                            col_d = col_q + COL_ONE;
                        end
                    end else begin
                        col_d = col_q;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_CLEAR: begin
                if (xfer_s) begin
                    if (wr_addr_q == ADDR_LAST) begin
                        wr_valid_d = 1'b0;
                        overrun_d  = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wr_valid_d = 1'b0;
            end
        endcase

        // A strobe in the cycle DECODE consumes the hold is accepted; a drop here outranks clear's reset.
        if (hold_free_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (rx_valid) begin
            if (!hold_full_q || hold_free_s) begin
                hold_full_d = 1'b1;
                hold_data_d = rx_data;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            hold_data_d = hold_data_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= 8'h00;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_char_q   <= 8'h00;
            col_q       <= {COL_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            advance_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_char_q   <= wr_char_d;
            col_q       <= col_d;
            row_q       <= row_d;
            advance_q   <= advance_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_TEXT_ECHO_EN
    // Echo holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
`endif

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_char    = wr_char_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE) || hold_full_q;
endmodule
